// File: rtl/panda_risc_v_alu_res_buf.sv
// ALU result buffer: 2-entry FIFO toward commit plus branch resolution.
// A mispredicted branch raises a held flush request and wrong-path results are filtered.
module panda_risc_v_alu_res_buf #(
   parameter int unsigned inst_id_width = 4,
   parameter string       en_flush_drop = "true"
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [1:0]               s_inst_type,
   input  logic [inst_id_width-1:0] s_inst_id,
   input  logic [4:0]               s_rd_id,
   input  logic [31:0]              s_alu_res,
   input  logic                     s_brc_cond_res,
   input  logic [31:0]              s_ls_addr,
   input  logic                     s_pred_taken,
   input  logic [31:0]              s_brc_target,
   input  logic [31:0]              s_pc_nxt,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [inst_id_width-1:0] m_inst_id,
   output logic [4:0]               m_rd_id,
   output logic                     m_rd_wen,
   output logic [31:0]              m_res,
   output logic                     flush_req,
   output logic [31:0]              flush_addr,
   input  logic                     flush_ack
);

   localparam bit DROP_ON_FLUSH = (en_flush_drop == "true");

   typedef enum logic {
      NORMAL,
      FLUSH_WAIT
   } state_t;

   state_t state_q;

   logic [inst_id_width-1:0] id_q  [0:1];
   logic [4:0]               rd_q  [0:1];
   logic                     wen_q [0:1];
   logic [31:0]              res_q [0:1];

   logic        wptr_q, wptr_d;
   logic        rptr_q, rptr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] flush_addr_q;

   logic        full;
   logic        accept;
   logic        push;
   logic        pop;
   logic        mispredict;
   logic        entry_wen;
   logic [31:0] entry_res;

   always_comb begin
      full = (cnt_q == 2'd2);
      if ((state_q == FLUSH_WAIT) && !DROP_ON_FLUSH)
         s_ready = 1'b0;
      else
         s_ready = ~full;
      accept = s_valid & s_ready;
      // Inputs accepted while a flush is pending are wrong-path: consumed, never stored.
      push       = accept & (state_q == NORMAL);
      pop        = m_valid & m_ready;
      mispredict = push & (s_inst_type == 2'd1) & (s_brc_cond_res != s_pred_taken);
   end

   always_comb begin
      entry_wen = (s_inst_type == 2'd0) & (s_rd_id != 5'd0);
      case (s_inst_type)
         2'd1:    entry_res = {31'd0, s_brc_cond_res};
         2'd2:    entry_res = s_ls_addr;
         default: entry_res = s_alu_res;
      endcase
   end

   always_comb begin
      wptr_d = push ? ~wptr_q : wptr_q;
      rptr_d = pop ? ~rptr_q : rptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         cnt_q  <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            id_q[i]  <= '0;
            rd_q[i]  <= '0;
            wen_q[i] <= 1'b0;
            res_q[i] <= '0;
         end
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (push) begin
            id_q[wptr_q]  <= s_inst_id;
            rd_q[wptr_q]  <= s_rd_id;
            wen_q[wptr_q] <= entry_wen;
            res_q[wptr_q] <= entry_res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= NORMAL;
         flush_addr_q <= '0;
      end else begin
         case (state_q)
            NORMAL: begin
               if (mispredict) begin
                  state_q      <= FLUSH_WAIT;
                  flush_addr_q <= s_brc_cond_res ? s_brc_target : s_pc_nxt;
               end
            end
            FLUSH_WAIT: begin
               if (flush_ack)
                  state_q <= NORMAL;
            end
            default: state_q <= NORMAL;
         endcase
      end
   end

   assign m_valid    = (cnt_q != 2'd0);
   assign m_inst_id  = id_q[rptr_q];
   assign m_rd_id    = rd_q[rptr_q];
   assign m_rd_wen   = wen_q[rptr_q];
   assign m_res      = res_q[rptr_q];
   assign flush_req  = (state_q == FLUSH_WAIT);
   assign flush_addr = flush_addr_q;

endmodule

// File: tb/tb_panda_risc_v_alu_res_buf.sv
// Bench for panda_risc_v_alu_res_buf: scoreboard of expected commit entries
// plus per-scenario checks of handshake and flush behaviour.
module tb_panda_risc_v_alu_res_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [1:0]  s_inst_type;
   logic [3:0]  s_inst_id;
   logic [4:0]  s_rd_id;
   logic [31:0] s_alu_res;
   logic        s_brc_cond_res;
   logic [31:0] s_ls_addr;
   logic        s_pred_taken;
   logic [31:0] s_brc_target;
   logic [31:0] s_pc_nxt;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_inst_id;
   logic [4:0]  m_rd_id;
   logic        m_rd_wen;
   logic [31:0] m_res;
   logic        flush_req;
   logic [31:0] flush_addr;
   logic        flush_ack;

   panda_risc_v_alu_res_buf #(
      .inst_id_width(4),
      .en_flush_drop("true")
   ) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_inst_type(s_inst_type),
      .s_inst_id(s_inst_id), .s_rd_id(s_rd_id), .s_alu_res(s_alu_res),
      .s_brc_cond_res(s_brc_cond_res), .s_ls_addr(s_ls_addr),
      .s_pred_taken(s_pred_taken), .s_brc_target(s_brc_target), .s_pc_nxt(s_pc_nxt),
      .m_valid(m_valid), .m_ready(m_ready), .m_inst_id(m_inst_id), .m_rd_id(m_rd_id),
      .m_rd_wen(m_rd_wen), .m_res(m_res),
      .flush_req(flush_req), .flush_addr(flush_addr), .flush_ack(flush_ack)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  id;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] res;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   logic [3:0] next_id = 4'd0;

   // Commit-side scoreboard: every popped head must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL commit_unexpected: got id=%0d res=%h, expected no output", m_inst_id, m_res);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({m_inst_id, m_rd_id, m_rd_wen, m_res} !== e)
               $display("FAIL commit_entry: got id=%0d rd=%0d wen=%0d res=%h, expected id=%0d rd=%0d wen=%0d res=%h",
                        m_inst_id, m_rd_id, m_rd_wen, m_res, e.id, e.rd, e.wen, e.res);
            else
               n_pass++;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send(input logic [1:0] ty, input logic [4:0] rd, input logic [31:0] alu,
                       input logic cond, input logic [31:0] ls, input logic pred,
                       input logic [31:0] tgt, input logic [31:0] pcn, input bit keep);
      exp_t e;
      int   waited;
      s_valid = 1'b1; s_inst_type = ty; s_inst_id = next_id; s_rd_id = rd;
      s_alu_res = alu; s_brc_cond_res = cond; s_ls_addr = ls; s_pred_taken = pred;
      s_brc_target = tgt; s_pc_nxt = pcn;
      @(negedge clk);
      waited = 0;
      while (s_ready !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (s_ready !== 1'b1) begin
         n_total++;
         $display("FAIL send_timeout: s_ready=%b, expected 1 within 40 cycles", s_ready);
      end else if (keep) begin
         e.id  = next_id;
         e.rd  = rd;
         e.wen = (ty == 2'd0) && (rd != 5'd0);
         case (ty)
            2'd1:    e.res = {31'd0, cond};
            2'd2:    e.res = ls;
            default: e.res = alu;
         endcase
         exp_q.push_back(e);
      end
      next_id = next_id + 4'd1;
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic drain();
      int waited = 0;
      while (exp_q.size() != 0 && waited < 40) begin
         @(posedge clk);
         waited++;
      end
      #1;
      n_total++;
      if (exp_q.size() != 0) $display("FAIL drain: %0d entries outstanding, expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({m_valid, s_ready, flush_req} !== 3'b010)
         $display("FAIL reset_ctrl: m_valid/s_ready/flush_req=%b, expected 010", {m_valid, s_ready, flush_req});
      else n_pass++;
      n_total++;
      if ({flush_addr, m_res, m_inst_id, m_rd_id, m_rd_wen} !== '0)
         $display("FAIL reset_data: flush_addr=%h m_res=%h id=%0d rd=%0d wen=%b, expected all 0",
                  flush_addr, m_res, m_inst_id, m_rd_id, m_rd_wen);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      m_ready = 1'b1;
      next_id = 4'd0;
      send(2'd0, 5'd5, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      n_total++;
      if (m_valid !== 1'b1 || m_res !== 32'h1234_5678 || m_rd_wen !== 1'b1)
         $display("FAIL basic_latency: m_valid=%b m_res=%h wen=%b, expected 1 12345678 1", m_valid, m_res, m_rd_wen);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (m_valid !== 1'b0) $display("FAIL basic_empty: m_valid=%b, expected 0", m_valid);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      m_ready = 1'b0;
      next_id = 4'd0;
      send(2'd0, 5'd1, 32'hA000_0001, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      send(2'd0, 5'd2, 32'hA000_0002, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      n_total++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_inst_id !== 4'd0)
         $display("FAIL full_stall: s_ready=%b m_valid=%b head_id=%0d, expected 0 1 0", s_ready, m_valid, m_inst_id);
      else n_pass++;
      @(posedge clk);
      #1 m_ready = 1'b1;
      send(2'd3, 5'd3, 32'hA000_0003, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      drain();
   endtask

   task automatic test_mispredict_taken();
      m_ready = 1'b1;
      send(2'd1, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h8000_0100, 32'h8000_0008, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_total++;
         if (flush_req !== 1'b1 || flush_addr !== 32'h8000_0100)
            $display("FAIL flush_hold: cycle %0d flush_req=%b flush_addr=%h, expected 1 80000100", i, flush_req, flush_addr);
         else n_pass++;
         @(posedge clk); #1;
      end
      send(2'd0, 5'd4, 32'hDEAD_0001, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      send(2'd1, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h9000_0000, 32'h0, 1'b0);
      @(negedge clk);
      n_total++;
      if (flush_req !== 1'b1 || flush_addr !== 32'h8000_0100 || m_valid !== 1'b0)
         $display("FAIL flush_discard: flush_req=%b flush_addr=%h m_valid=%b, expected 1 80000100 0",
                  flush_req, flush_addr, m_valid);
      else n_pass++;
      @(posedge clk);
      #1 flush_ack = 1'b1;
      send(2'd0, 5'd6, 32'hDEAD_0002, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      flush_ack = 1'b0;
      @(negedge clk);
      n_total++;
      if (flush_req !== 1'b0 || m_valid !== 1'b0)
         $display("FAIL flush_release: flush_req=%b m_valid=%b, expected 0 0", flush_req, m_valid);
      else n_pass++;
      @(posedge clk); #1;
      drain();
   endtask

   task automatic test_mispredict_not_taken();
      m_ready = 1'b1;
      send(2'd1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_0200, 32'h8000_0014, 1'b1);
      @(negedge clk);
      n_total++;
      if (flush_req !== 1'b1 || flush_addr !== 32'h8000_0014)
         $display("FAIL flush_not_taken: flush_req=%b flush_addr=%h, expected 1 80000014", flush_req, flush_addr);
      else n_pass++;
      @(posedge clk);
      #1 flush_ack = 1'b1;
      @(posedge clk);
      #1 flush_ack = 1'b0;
      send(2'd1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h8000_0200, 32'h8000_0014, 1'b1);
      send(2'd1, 5'd0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h8000_0300, 32'h8000_0018, 1'b1);
      @(negedge clk);
      n_total++;
      if (flush_req !== 1'b0)
         $display("FAIL correct_pred: flush_req=%b, expected 0", flush_req);
      else n_pass++;
      @(posedge clk); #1;
      drain();
   endtask

   task automatic test_types();
      m_ready = 1'b1;
      send(2'd2, 5'd7, 32'h1111_1111, 1'b0, 32'h2000_0008, 1'b0, 32'h0, 32'h0, 1'b1);
      send(2'd0, 5'd0, 32'h2222_2222, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      send(2'd3, 5'd9, 32'h3333_3333, 1'b0, 32'h4444_4444, 1'b0, 32'h0, 32'h0, 1'b1);
      send(2'd0, 5'd31, 32'h5555_5555, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      n_total++;
      if (flush_req !== 1'b0)
         $display("FAIL types_no_flush: flush_req=%b, expected 0", flush_req);
      else n_pass++;
      drain();
   endtask

   task automatic test_rst_mid();
      m_ready = 1'b0;
      send(2'd0, 5'd3, 32'h7777_0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      send(2'd1, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h8000_0400, 32'h0, 1'b1);
      @(negedge clk);
      n_total++;
      if ({flush_req, m_valid, s_ready} !== 3'b110)
         $display("FAIL pre_rst: flush_req/m_valid/s_ready=%b, expected 110", {flush_req, m_valid, s_ready});
      else n_pass++;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      n_total++;
      if ({m_valid, flush_req, s_ready} !== 3'b001 || flush_addr !== 32'h0)
         $display("FAIL rst_mid: m_valid/flush_req/s_ready=%b flush_addr=%h, expected 001 00000000",
                  {m_valid, flush_req, s_ready}, flush_addr);
      else n_pass++;
      @(posedge clk); #1;
      m_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_inst_type = '0; s_inst_id = '0; s_rd_id = '0;
      s_alu_res = '0; s_brc_cond_res = 1'b0; s_ls_addr = '0; s_pred_taken = 1'b0;
      s_brc_target = '0; s_pc_nxt = '0; m_ready = 1'b0; flush_ack = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_mispredict_taken();
      test_mispredict_not_taken();
      test_types();
      test_rst_mid();
      test_basic();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
